// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and memory-wait controller for the 5-stage pipeline.
// Define PIPE_HAZARD_FWD_EN to enable operand forwarding; otherwise every RAW hazard stalls.
//
// state  | meaning
// S_IDLE | no load waiting on data memory
// S_WAIT | load in MEM waiting out its read latency, cnt = cycles left
module pipe_hazard_ctrl #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 4,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_en,
   input  logic [REG_AW-1:0] id_rs0,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs0_used,
   input  logic              id_rs1_used,
   input  logic              id_branch_taken,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              ex_wen,
   input  logic              mem_wen,
   input  logic              wb_wen,
   input  logic              ex_is_load,
   input  logic              mem_is_load,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] rf_rs0_data,
   input  logic [DATA_W-1:0] rf_rs1_data,
   output logic [DATA_W-1:0] op0,
   output logic [DATA_W-1:0] op1,
   output logic [1:0]        fwd_sel0,
   output logic [1:0]        fwd_sel1,
   output logic              stall_all,
   output logic              hold_front,
   output logic              bubble_ex,
   output logic              flush_if_id,
   output logic              mem_wait,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        load_in_mem;
   logic        stall_raw;
   logic        hazard;
   logic        ex_hit0, mem_hit0, wb_hit0;
   logic        ex_hit1, mem_hit1, wb_hit1;
   logic [DATA_W-1:0] mem_fwd;

   assign load_in_mem = mem_is_load & mem_wen;
   assign stall_raw   = load_in_mem & ((state == S_IDLE) | (cnt != 4'd0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (pipe_en) begin
         case (state)
            S_IDLE: begin
               if (load_in_mem) begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = LAT_M1;
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
               else             state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign ex_hit0  = id_rs0_used & ex_wen  & (ex_rd  == id_rs0);
   assign mem_hit0 = id_rs0_used & mem_wen & (mem_rd == id_rs0);
   assign wb_hit0  = id_rs0_used & wb_wen  & (wb_rd  == id_rs0);
   assign ex_hit1  = id_rs1_used & ex_wen  & (ex_rd  == id_rs1);
   assign mem_hit1 = id_rs1_used & mem_wen & (mem_rd == id_rs1);
   assign wb_hit1  = id_rs1_used & wb_wen  & (wb_rd  == id_rs1);

   assign mem_fwd = mem_is_load ? mem_rdata : mem_result;

   // A load in EX has no data yet, so it is skipped for forwarding and stalls instead.
   always_comb begin
      fwd_sel0 = 2'd0;
      fwd_sel1 = 2'd0;
`ifdef PIPE_HAZARD_FWD_EN
      if (ex_hit0 & !ex_is_load) fwd_sel0 = 2'd1;
      else if (mem_hit0)         fwd_sel0 = 2'd2;
      else if (wb_hit0)          fwd_sel0 = 2'd3;
      if (ex_hit1 & !ex_is_load) fwd_sel1 = 2'd1;
      else if (mem_hit1)         fwd_sel1 = 2'd2;
      else if (wb_hit1)          fwd_sel1 = 2'd3;
      hazard = ex_is_load & (ex_hit0 | ex_hit1);
`else
      hazard = ex_hit0 | mem_hit0 | wb_hit0 | ex_hit1 | mem_hit1 | wb_hit1;
`endif
   end

   always_comb begin
      case (fwd_sel0)
         2'd1:    op0 = ex_result;
         2'd2:    op0 = mem_fwd;
         2'd3:    op0 = wb_data;
         default: op0 = rf_rs0_data;
      endcase
      case (fwd_sel1)
         2'd1:    op1 = ex_result;
         2'd2:    op1 = mem_fwd;
         2'd3:    op1 = wb_data;
         default: op1 = rf_rs1_data;
      endcase
   end

   assign stall_all   = reset & stall_raw;
   assign hold_front  = reset & !stall_raw & hazard;
   assign bubble_ex   = reset & !stall_raw & hazard;
   assign flush_if_id = reset & id_branch_taken & !stall_raw & !hazard;
   assign mem_wait    = (state == S_WAIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cycles <= '0;
      else if (pipe_en & (stall_all | hold_front) & (stall_cycles != {CNT_W{1'b1}}))
         stall_cycles <= stall_cycles + 1'b1;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: dut_a (MEM_LAT=3, CNT_W=4), dut_b (MEM_LAT=2, CNT_W=16).
// Expectations follow PIPE_HAZARD_FWD_EN when it is defined for the build.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_en;
   logic [3:0]  id_rs0, id_rs1, ex_rd, mem_rd, wb_rd;
   logic        id_rs0_used, id_rs1_used, id_branch_taken;
   logic        ex_wen, mem_wen, wb_wen, ex_is_load, mem_is_load;
   logic [31:0] ex_result, mem_result, mem_rdata, wb_data, rf_rs0_data, rf_rs1_data;

   logic [31:0] op0_a, op1_a, op0_b, op1_b;
   logic [1:0]  fwd_sel0_a, fwd_sel1_a, fwd_sel0_b, fwd_sel1_b;
   logic        stall_all_a, hold_front_a, bubble_ex_a, flush_if_id_a, mem_wait_a;
   logic        stall_all_b, hold_front_b, bubble_ex_b, flush_if_id_b, mem_wait_b;
   logic [3:0]  stall_cycles_a;
   logic [15:0] stall_cycles_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(4), .MEM_LAT(3), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .pipe_en(pipe_en),
      .id_rs0(id_rs0), .id_rs1(id_rs1), .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
      .id_branch_taken(id_branch_taken),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
      .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
      .ex_result(ex_result), .mem_result(mem_result), .mem_rdata(mem_rdata), .wb_data(wb_data),
      .rf_rs0_data(rf_rs0_data), .rf_rs1_data(rf_rs1_data),
      .op0(op0_a), .op1(op1_a), .fwd_sel0(fwd_sel0_a), .fwd_sel1(fwd_sel1_a),
      .stall_all(stall_all_a), .hold_front(hold_front_a), .bubble_ex(bubble_ex_a),
      .flush_if_id(flush_if_id_a), .mem_wait(mem_wait_a), .stall_cycles(stall_cycles_a)
   );

   pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(4), .MEM_LAT(2), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .pipe_en(pipe_en),
      .id_rs0(id_rs0), .id_rs1(id_rs1), .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
      .id_branch_taken(id_branch_taken),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
      .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
      .ex_result(ex_result), .mem_result(mem_result), .mem_rdata(mem_rdata), .wb_data(wb_data),
      .rf_rs0_data(rf_rs0_data), .rf_rs1_data(rf_rs1_data),
      .op0(op0_b), .op1(op1_b), .fwd_sel0(fwd_sel0_b), .fwd_sel1(fwd_sel1_b),
      .stall_all(stall_all_b), .hold_front(hold_front_b), .bubble_ex(bubble_ex_b),
      .flush_if_id(flush_if_id_b), .mem_wait(mem_wait_b), .stall_cycles(stall_cycles_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      pipe_en = 1'b1;
      id_rs0 = 4'd0; id_rs1 = 4'd0; id_rs0_used = 1'b0; id_rs1_used = 1'b0;
      id_branch_taken = 1'b0;
      ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
      ex_wen = 1'b0; mem_wen = 1'b0; wb_wen = 1'b0; ex_is_load = 1'b0; mem_is_load = 1'b0;
      ex_result = 32'h5; mem_result = 32'h66; mem_rdata = 32'hA5; wb_data = 32'h77;
      rf_rs0_data = 32'h111; rf_rs1_data = 32'h222;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      mem_is_load = 1'b1; mem_wen = 1'b1; mem_rd = 4'd2;
      ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 4'd3; id_rs0 = 4'd3; id_rs0_used = 1'b1;
      id_branch_taken = 1'b1;
      step();
      step();
      n_checks++;
      if ({stall_all_a, hold_front_a, bubble_ex_a, flush_if_id_a, mem_wait_a} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {stall_all_a, hold_front_a, bubble_ex_a, flush_if_id_a, mem_wait_a});
      end
      n_checks++;
      if (stall_cycles_a !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles_a);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_alu_raw();
      logic [1:0]  exp_sel [4];
      logic [31:0] exp_op  [4];
      logic        exp_hold[4];
      logic [3:0]  exp_cnt;
`ifdef PIPE_HAZARD_FWD_EN
      exp_sel  = '{2'd1, 2'd2, 2'd3, 2'd0};
      exp_op   = '{32'h5, 32'h66, 32'h77, 32'h111};
      exp_hold = '{1'b0, 1'b0, 1'b0, 1'b0};
      exp_cnt  = 4'd0;
`else
      exp_sel  = '{2'd0, 2'd0, 2'd0, 2'd0};
      exp_op   = '{32'h111, 32'h111, 32'h111, 32'h111};
      exp_hold = '{1'b1, 1'b1, 1'b1, 1'b0};
      exp_cnt  = 4'd3;
`endif
      do_reset();
      id_rs0 = 4'd1; id_rs0_used = 1'b1;
      id_rs1 = 4'd1; id_rs1_used = 1'b0;
      for (int c = 0; c < 4; c++) begin
         ex_wen  = (c == 0);
         mem_wen = (c == 1); mem_rd = 4'd1;
         wb_wen  = (c == 2); wb_rd  = 4'd1;
         ex_rd   = 4'd1;
         #1;
         n_checks++;
         if (fwd_sel0_a !== exp_sel[c] || op0_a !== exp_op[c]) begin
            n_fail++;
            $display("FAIL alu_raw_op0 c%0d: got sel %0d op %h want sel %0d op %h",
                     c, fwd_sel0_a, op0_a, exp_sel[c], exp_op[c]);
         end
         n_checks++;
         if (hold_front_a !== exp_hold[c] || bubble_ex_a !== exp_hold[c] || stall_all_a !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_raw_stall c%0d: got hold %b bubble %b stall %b want hold %b stall 0",
                     c, hold_front_a, bubble_ex_a, stall_all_a, exp_hold[c]);
         end
         n_checks++;
         if (fwd_sel1_a !== 2'd0 || op1_a !== 32'h222) begin
            n_fail++;
            $display("FAIL alu_raw_unused c%0d: got sel %0d op %h want sel 0 op 222",
                     c, fwd_sel1_a, op1_a);
         end
         step();
      end
      n_checks++;
      if (stall_cycles_a !== exp_cnt) begin
         n_fail++;
         $display("FAIL alu_raw_count: got %0d want %0d", stall_cycles_a, exp_cnt);
      end
      // EX and MEM both writing r1: EX is the newer value and must win
      ex_wen = 1'b1; mem_wen = 1'b1; wb_wen = 1'b0;
      #1;
      n_checks++;
`ifdef PIPE_HAZARD_FWD_EN
      if (fwd_sel0_a !== 2'd1 || op0_a !== 32'h5) begin
         n_fail++;
         $display("FAIL fwd_priority: got sel %0d op %h want sel 1 op 5", fwd_sel0_a, op0_a);
      end
`else
      if (hold_front_a !== 1'b1 || fwd_sel0_a !== 2'd0) begin
         n_fail++;
         $display("FAIL fwd_priority: got hold %b sel %0d want hold 1 sel 0", hold_front_a, fwd_sel0_a);
      end
`endif
   endtask

   task automatic test_load_use();
      do_reset();
      id_rs0 = 4'd2; id_rs0_used = 1'b1;
      ex_rd = 4'd2; ex_wen = 1'b1; ex_is_load = 1'b1;
      #1;
      n_checks++;
      if (hold_front_a !== 1'b1 || bubble_ex_a !== 1'b1 || stall_all_a !== 1'b0) begin
         n_fail++;
         $display("FAIL load_use_hold: got hold %b bubble %b stall %b want 1 1 0",
                  hold_front_a, bubble_ex_a, stall_all_a);
      end
      step();
      ex_wen = 1'b0; ex_is_load = 1'b0;
      mem_rd = 4'd2; mem_wen = 1'b1; mem_is_load = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (stall_all_a !== 1'b1 || hold_front_a !== 1'b0 || bubble_ex_a !== 1'b0
             || mem_wait_a !== (c != 0)) begin
            n_fail++;
            $display("FAIL load_use_wait c%0d: got stall %b hold %b bubble %b mem_wait %b want 1 0 0 %b",
                     c, stall_all_a, hold_front_a, bubble_ex_a, mem_wait_a, c != 0);
         end
         step();
      end
      #1;
      n_checks++;
`ifdef PIPE_HAZARD_FWD_EN
      if (stall_all_a !== 1'b0 || hold_front_a !== 1'b0 || fwd_sel0_a !== 2'd2 || op0_a !== 32'hA5) begin
         n_fail++;
         $display("FAIL load_use_release: got stall %b hold %b sel %0d op %h want 0 0 2 a5",
                  stall_all_a, hold_front_a, fwd_sel0_a, op0_a);
      end
`else
      if (stall_all_a !== 1'b0 || hold_front_a !== 1'b1 || fwd_sel0_a !== 2'd0 || op0_a !== 32'h111) begin
         n_fail++;
         $display("FAIL load_use_release: got stall %b hold %b sel %0d op %h want 0 1 0 111",
                  stall_all_a, hold_front_a, fwd_sel0_a, op0_a);
      end
`endif
      n_checks++;
      if (stall_cycles_a !== 4'd4) begin
         n_fail++;
         $display("FAIL load_use_count: got %0d want 4", stall_cycles_a);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_stall[5];
      exp_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      do_reset();
      mem_rd = 4'd3; mem_wen = 1'b1; mem_is_load = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if (stall_all_b !== exp_stall[c]) begin
            n_fail++;
            $display("FAIL back_to_back c%0d: got stall %b want %b", c, stall_all_b, exp_stall[c]);
         end
         step();
      end
      clear_inputs();
      #1;
      n_checks++;
      if (stall_cycles_b !== 16'd4) begin
         n_fail++;
         $display("FAIL back_to_back_count: got %0d want 4", stall_cycles_b);
      end
   endtask

   task automatic test_branch_wait();
      do_reset();
      mem_rd = 4'd4; mem_wen = 1'b1; mem_is_load = 1'b1;
      id_branch_taken = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (stall_all_a !== (c < 3) || flush_if_id_a !== (c == 3)) begin
            n_fail++;
            $display("FAIL branch_wait c%0d: got stall %b flush %b want %b %b",
                     c, stall_all_a, flush_if_id_a, c < 3, c == 3);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      mem_rd = 4'd6; mem_wen = 1'b1; mem_is_load = 1'b1;
      step();
      step();
      n_checks++;
      if (stall_all_a !== 1'b1 || mem_wait_a !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_wait_pre: got stall %b mem_wait %b want 1 1", stall_all_a, mem_wait_a);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (stall_all_a !== 1'b0 || mem_wait_a !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_wait_reset: got stall %b mem_wait %b want 0 0", stall_all_a, mem_wait_a);
      end
      #2;
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (stall_all_a !== (c < 3)) begin
            n_fail++;
            $display("FAIL mid_wait_restart c%0d: got stall %b want %b", c, stall_all_a, c < 3);
         end
         step();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      id_rs0 = 4'd5; id_rs0_used = 1'b1;
      ex_rd = 4'd5; ex_wen = 1'b1; ex_is_load = 1'b1;
      repeat (5) step();
      n_checks++;
      if (stall_cycles_a !== 4'd5) begin
         n_fail++;
         $display("FAIL sat_count5: got %0d want 5", stall_cycles_a);
      end
      pipe_en = 1'b0;
      #1;
      n_checks++;
      if (hold_front_a !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_hold_pipe_off: got hold %b want 1", hold_front_a);
      end
      repeat (3) step();
      n_checks++;
      if (stall_cycles_a !== 4'd5) begin
         n_fail++;
         $display("FAIL sat_pipe_off_hold: got %0d want 5", stall_cycles_a);
      end
      pipe_en = 1'b1;
      repeat (9) step();
      n_checks++;
      if (stall_cycles_a !== 4'd14) begin
         n_fail++;
         $display("FAIL sat_count14: got %0d want 14", stall_cycles_a);
      end
      repeat (5) step();
      n_checks++;
      if (stall_cycles_a !== 4'hF) begin
         n_fail++;
         $display("FAIL sat_count15: got %0d want 15", stall_cycles_a);
      end
   endtask

   initial begin
      test_reset();
      test_alu_raw();
      test_load_use();
      test_back_to_back();
      test_branch_wait();
      test_reset_mid_wait();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and memory-wait controller for the 5-stage ARMv8-M pipeline. It sits beside the IF/ID/EX/MEM/WB stage registers and produces four things:
- the global freeze;
- the front-end hold and EX bubble for load-use hazards;
- branch flushes;
- forwarded ID operands.

It replaces the fixed one-cycle load stall with a configurable data-memory read latency and adds operand forwarding. It keeps a saturating stall-cycle counter for debug readout.

## Interface
Parameters:
- DATA_W, 32, datapath and operand width
- REG_AW, 4, register address width
- MEM_LAT, 1, data-memory read latency in cycles; legal range 1..15
- CNT_W, 16, width of stall_cycles

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- pipe_en  in  1  global pipeline enable; when low, all state holds
- id_rs0, id_rs1  in  REG_AW  source register addresses in ID
- id_rs0_used, id_rs1_used  in  1  ID instruction actually reads that source
- id_branch_taken  in  1  branch resolved taken in ID
- ex_rd, mem_rd, wb_rd  in  REG_AW  destination register per stage
- ex_wen, mem_wen, wb_wen  in  1  stage will write its rd; already qualified by non-bubble
- ex_is_load, mem_is_load  in  1  stage holds a load (LDR)
- ex_result  in  DATA_W  ALU output in EX
- mem_result  in  DATA_W  ALU result held in EX/MEM
- mem_rdata  in  DATA_W  data-memory read data
- wb_data  in  DATA_W  MEM/WB write data
- rf_rs0_data, rf_rs1_data  in  DATA_W  register-file read data
- op0, op1  out  DATA_W  resolved ID operands
- fwd_sel0, fwd_sel1  out  2  source select: 0 RF, 1 EX, 2 MEM, 3 WB
- stall_all  out  1  freeze PC and all four stage registers
- hold_front  out  1  freeze PC and IF/ID
- bubble_ex  out  1  load bubble into ID/EX
- flush_if_id  out  1  load NOP into IF/ID
- mem_wait  out  1  memory FSM not idle
- stall_cycles  out  CNT_W  saturating count of stall_all or hold_front cycles

## Operation
- **Memory FSM, states IDLE and WAIT, 4-bit counter cnt.**
  - IDLE, with mem_is_load & mem_wen & pipe_en: go to WAIT, cnt <= MEM_LAT-1.
  - WAIT with cnt!=0: cnt decrements.
  - WAIT with cnt==0: return to IDLE.
  - stall_all = mem_is_load & mem_wen & (state==IDLE | cnt!=0).
  - Consequence: a load freezes the pipe for exactly MEM_LAT cycles, then advances with mem_rdata valid.
  - Back-to-back loads each pay MEM_LAT.
- **Load-use hazard:** ex_is_load & ex_wen & ID uses ex_rd. Response: hold_front=1 and bubble_ex=1.
- **Forward priority per operand:**
  - EX (ex_wen & !ex_is_load & rd match), else
  - MEM (mem_wen & rd match; value mem_rdata if mem_is_load else mem_result), else
  - WB (wb_wen & match), else RF.
  - Unused sources (id_rsN_used=0) select RF.
- **Flush:** flush_if_id = id_branch_taken & !stall_all & !hold_front. A held branch re-resolves the next cycle.
- **Priority:** stall_all overrides everything. While it is high, hold_front, bubble_ex and flush_if_id are forced 0.
- **stall_cycles:** increments when pipe_en & (stall_all | hold_front). It saturates at all-ones.
- **pipe_en low:** FSM, cnt and stall_cycles hold; combinational outputs remain valid.

## Timing
- **Reset values:** state=IDLE, cnt=0, stall_cycles=0. While reset is low, stall_all, hold_front, bubble_ex, flush_if_id and mem_wait are forced 0.
- **Reset mid-WAIT:** aborts immediately to IDLE. The pending load restarts its full MEM_LAT wait after release.
- **Combinational outputs:** op0/op1, fwd_sel, stall_all, hold_front, bubble_ex and flush_if_id have zero-cycle latency from inputs and state.
- **Registered outputs:** mem_wait and stall_cycles update on the clock edge.
- **Load-use cost:** exactly one hold cycle with forwarding, before any MEM_LAT wait.

## Configuration
- PIPE_HAZARD_FWD_EN defined: forwarding as above.
- PIPE_HAZARD_FWD_EN undefined:
  - op0/op1 always take RF data and fwd_sel is always 0.
  - hold_front and bubble_ex assert whenever any used source matches a writing rd in EX, MEM or WB, regardless of load.
  - The register file has no write-through, so the WB match also stalls.

## Test plan
- **ALU RAW chain.** ADD r1 in EX (ex_result=0x5), ID uses r1. Expected: fwd_sel0=1, op0=0x5, no stall. With the macro undefined: hold_front for 3 cycles.
- **Load-use.** LDR r2 in EX, ID reads r2. Expected: hold_front=bubble_ex=1 for 1 cycle. Then, with MEM_LAT=3, stall_all for 3 cycles. Then op0=mem_rdata (0xA5) with fwd_sel0=2.
- **Back-to-back loads, MEM_LAT=2.** Expected: stall_all high 2 cycles, low 1, high 2; stall_cycles=4.
- **Branch during memory wait.** id_branch_taken=1 while stall_all=1. Expected: flush_if_id=0. It asserts the first cycle stall_all drops.
- **Reset mid-WAIT.** Pull reset low at cnt=1 with MEM_LAT=3. Expected: stall_all=0 and mem_wait=0 immediately. After release, 3 fresh stall cycles.
- **Counter saturation.** CNT_W=4 with continuous stall. Expected: stall_cycles stops at 0xF. With pipe_en=0, the count holds.
